// File: rtl/unibus4_pkg.sv
// Shared types and constants for the 4-bit Unibus-style target.
package unibus4_pkg;
  localparam int U4_DATA_W = 4;
  localparam int U4_ADDR_W = 4;
  localparam int U4_NREGS  = 4;

  typedef enum logic [2:0] {
    U4_IDLE,
    U4_DESKEW,
    U4_ACCESS,
    U4_RESP,
    U4_IGNORE
  } u4_state_t;
endpackage

// File: rtl/unibus4_regfile.sv
// Four-entry register bank: async clear, one write port, combinational read.
module unibus4_regfile
  import unibus4_pkg::*;
#(
  parameter int DATA_W = U4_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic [1:0]                  i_waddr,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [1:0]                  i_raddr,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [U4_NREGS*DATA_W-1:0]  o_regs
);
  logic [U4_NREGS-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_regs          <= '0;
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_regs[i_raddr];
  assign o_regs  = r_regs;
endmodule

// File: rtl/unibus4_target.sv
// Bus target: deskews msyn, decodes a 4-register window at BASE_ADDR and
// completes the four-phase msyn/ssyn handshake.
module unibus4_target
  import unibus4_pkg::*;
#(
  parameter int                DATA_W      = U4_DATA_W,
  parameter int                ADDR_W      = U4_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(8),
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          msyn,
  input  logic [ADDR_W-1:0]             bus_addr,
  input  logic                          bus_we,
  input  logic [DATA_W-1:0]             bus_wdata,
  output logic                          ssyn,
  output logic [DATA_W-1:0]             bus_rdata,
  output logic                          rdata_en,
  output logic [U4_NREGS*DATA_W-1:0]    regs_q,
  output logic                          wr_strobe
);
  // With WAIT_CYCLES=0 DESKEW is never entered, so the clamp is harmless.
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  u4_state_t         r_state;
  logic [2:0]        r_cnt;
  logic              r_ssyn;
  logic              r_rdata_en;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr_strobe;

  logic              w_hit;
  logic              w_reg_we;
  logic [DATA_W-1:0] w_reg_rdata;

  assign w_hit    = (bus_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign w_reg_we = (r_state == U4_ACCESS) && msyn && w_hit && bus_we;

  unibus4_regfile #(.DATA_W(DATA_W)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_reg_we),
    .i_waddr (bus_addr[1:0]),
    .i_wdata (bus_wdata),
    .i_raddr (bus_addr[1:0]),
    .o_rdata (w_reg_rdata),
    .o_regs  (regs_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= U4_IDLE;
      r_cnt       <= '0;
      r_ssyn      <= 1'b0;
      r_rdata_en  <= 1'b0;
      r_rdata     <= '0;
      r_wr_strobe <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      case (r_state)
        U4_IDLE: if (msyn) begin
          r_cnt   <= '0;
          r_state <= (WAIT_CYCLES == 0) ? U4_ACCESS : U4_DESKEW;
        end
        U4_DESKEW: begin
          r_cnt <= r_cnt + 3'd1;
          if (!msyn)                  r_state <= U4_IDLE;
          else if (r_cnt == LAST_CNT) r_state <= U4_ACCESS;
        end
        U4_ACCESS: begin
          if (!msyn) r_state <= U4_IDLE;
          else if (w_hit) begin
            r_ssyn  <= 1'b1;
            r_state <= U4_RESP;
            if (bus_we) r_wr_strobe <= 1'b1;
            else begin
              r_rdata_en <= 1'b1;
              r_rdata    <= w_reg_rdata;
            end
          end else r_state <= U4_IGNORE;
        end
        // Read data stays latched until the master releases msyn.
        U4_RESP: if (!msyn) begin
          r_ssyn     <= 1'b0;
          r_rdata_en <= 1'b0;
          r_rdata    <= '0;
          r_state    <= U4_IDLE;
        end
        U4_IGNORE: if (!msyn) r_state <= U4_IDLE;
        default: r_state <= U4_IDLE;
      endcase
    end
  end

  assign ssyn      = r_ssyn;
  assign rdata_en  = r_rdata_en;
  assign bus_rdata = r_rdata;
  assign wr_strobe = r_wr_strobe;
endmodule
